// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, FSM states and lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. EX decode imports the same package so op codes stay in lock-step.
package mem_access_stage_pkg;

  // 4-bit memory operation codes carried from EX decode
  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    MEMST_IDLE   = 1'b0,
    MEMST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  // Little-endian byte enables for the access width; loads use the same lanes as stores
  function automatic logic [3:0] op_be(input mem_op_e op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: be = 4'b0001 << lo;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: be = lo[1] ? 4'b1100 : 4'b0011;
      default:                       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lanes always carry the right bytes
  function automatic logic [31:0] op_wdata(input mem_op_e op, input logic [31:0] d);
    logic [31:0] w;
    case (op)
      MEMOP_SB: w = {4{d[7:0]}};
      MEMOP_SH: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0
  function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] lo);
    logic m;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: m = lo[0];
      MEMOP_LW, MEMOP_SW:            m = |lo;
      default:                       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load alignment: picks byte/halfword from the read word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: i_rdata (read word), i_addr_lo (address bits [1:0]), i_mem_op (op code),
//        o_data (aligned, extended 32-bit load value).
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  mem_op_e     i_mem_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Halfword lane chosen by addr[1] only; addr[0] is ignored for halfwords
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_mem_op)
      MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_data = {24'd0, w_byte};
      MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_data = {16'd0, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: ALU result becomes a data address (load/store) or passes straight to WB.
// Latency: 1 cycle for non-memory ops, >=2 cycles accept-to-wb_valid for loads/stores.
// Backpressure: mem_stall is high for every ACCESS cycle; EX holds while it is asserted.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses raise addr_exc and
// load bad_vaddr instead of issuing a request; otherwise addr_exc/bad_vaddr are tied 0.
// Ports: clk/rst (sync, active high); flush; ex_* instruction from EX; mem_stall to EX;
//        dmem_* req/ack data-memory port; wb_* registered writeback; bus_err, addr_exc,
//        bad_vaddr fault reporting.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        addr_exc,
  output logic [31:0] bad_vaddr
);

  localparam logic                 LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int                   LP_LAST_I  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_WIDTH-1:0] LP_TO_LAST = CNT_WIDTH'(LP_LAST_I);

  mem_state_e r_state, w_state_nxt;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_abort;
  logic                 r_req, r_we;
  logic [31:0]          r_addr, r_wdata;
  logic [3:0]           r_be;
  logic [1:0]           r_addr_lo;
  mem_op_e              r_op;
  logic [4:0]           r_rd;
  logic                 r_reg_write;
  logic                 r_wb_valid, r_wb_reg_write;
  logic [4:0]           r_wb_rd;
  logic [31:0]          r_wb_data;
  logic                 r_bus_err;

  mem_op_e     w_op;
  logic        w_accept, w_is_mem, w_misalign;
  logic        w_issue, w_pass, w_fault, w_retire, w_timeout_hit, w_retire_vld;
  logic [31:0] w_load_data;

  assign w_op      = mem_op_e'(ex_mem_op);
  assign mem_stall = (r_state == MEMST_ACCESS);
  assign w_accept  = ex_valid && !mem_stall && !flush;
  assign w_is_mem  = is_load(w_op) || is_store(w_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = op_misaligned(w_op, ex_alu_result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= MEMST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus single-cycle event strobes consumed by the datapath below
  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_pass        = 1'b0;
    w_fault       = 1'b0;
    w_retire      = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      MEMST_IDLE: begin
        // dmem_ack is deliberately not looked at here
        if (w_accept) begin
          if (!w_is_mem) begin
            w_pass = 1'b1;
          end else if (w_misalign) begin
            w_fault = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = MEMST_ACCESS;
          end
        end
      end
      MEMST_ACCESS: begin
        // An ack on the last allowed cycle wins over the timeout
        if (dmem_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = MEMST_IDLE;
        end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = MEMST_IDLE;
        end
      end
      default: w_state_nxt = MEMST_IDLE;
    endcase
  end

  // A flush arriving with the ack still squashes the result
  assign w_retire_vld = w_retire && !r_abort && !flush;

  mem_access_stage_load_align u_load_align (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_mem_op  (r_op),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_abort        <= 1'b0;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_addr_lo      <= '0;
      r_op           <= MEMOP_NONE;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_bus_err      <= 1'b0;
    end else begin
      // Pulses default low; wb_reg_write only asserts alongside wb_valid
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_bus_err      <= 1'b0;

      if (w_pass) begin
        r_wb_valid     <= 1'b1;
        r_wb_data      <= ex_alu_result;
        r_wb_rd        <= ex_rd;
        r_wb_reg_write <= ex_reg_write;
      end

      if (w_issue) begin
        r_req       <= 1'b1;
        r_we        <= is_store(w_op);
        r_addr      <= {ex_alu_result[31:2], 2'b00};
        r_be        <= op_be(w_op, ex_alu_result[1:0]);
        r_wdata     <= op_wdata(w_op, ex_store_data);
        r_addr_lo   <= ex_alu_result[1:0];
        r_op        <= w_op;
        r_rd        <= ex_rd;
        r_reg_write <= ex_reg_write;
        r_cnt       <= '0;
        r_abort     <= 1'b0;
      end

      if (r_state == MEMST_ACCESS) begin
        // Flushed accesses still run to completion so the bus sees a clean handshake
        if (flush) r_abort <= 1'b1;
        if (LP_TO_EN && !dmem_ack) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      if (w_retire) begin
        r_req   <= 1'b0;
        r_abort <= 1'b0;
        r_cnt   <= '0;
        if (w_retire_vld) begin
          r_wb_valid     <= 1'b1;
          r_wb_rd        <= r_rd;
          r_wb_reg_write <= r_reg_write && !r_we;
          r_wb_data      <= r_we ? 32'd0 : w_load_data;
        end
      end

      if (w_timeout_hit) begin
        r_req     <= 1'b0;
        r_abort   <= 1'b0;
        r_cnt     <= '0;
        r_bus_err <= 1'b1;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic        r_addr_exc;
  logic [31:0] r_bad_vaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_exc  <= 1'b0;
      r_bad_vaddr <= '0;
    end else begin
      r_addr_exc <= w_fault;
      if (w_fault) r_bad_vaddr <= ex_alu_result;
    end
  end

  assign addr_exc  = r_addr_exc;
  assign bad_vaddr = r_bad_vaddr;
`else
  logic w_fault_unused;
  assign w_fault_unused = w_fault;
  assign addr_exc  = 1'b0;
  assign bad_vaddr = 32'd0;
`endif

  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_data      = r_wb_data;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        bus_err;
  logic        addr_exc;
  logic [31:0] bad_vaddr;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_op(ex_mem_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .bus_err(bus_err), .addr_exc(addr_exc), .bad_vaddr(bad_vaddr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    ex_valid      = 1'b0;
    flush         = 1'b0;
    dmem_ack      = 1'b0;
    ex_mem_op     = 4'd0;
    ex_alu_result = 32'd0;
    ex_store_data = 32'd0;
    ex_rd         = 5'd0;
    ex_reg_write  = 1'b0;
  endtask

  task automatic drive(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_result = addr;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb_data;
    logic        wb_rw;
  } vec_t;

  vec_t vecs[12];

  // Watchdog: the sequences below are all fixed-length, this only guards against a hung sim
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt;
    int wbv_cnt;
    int berr_cnt;

    //            op          addr          sdata         rdata         rd  rw be       wdata         wb_data       wb_rw
    vecs[0]  = '{MEMOP_NONE, 32'h00000010, 32'h0,        32'h0,        5, 1, 4'b0000, 32'h0,        32'h00000010, 1};
    vecs[1]  = '{MEMOP_LB,   32'h00001003, 32'h0,        32'h80FF1234, 2, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 1};
    vecs[2]  = '{MEMOP_LBU,  32'h00001003, 32'h0,        32'h80FF1234, 3, 1, 4'b1000, 32'h0,        32'h00000080, 1};
    vecs[3]  = '{MEMOP_LH,   32'h00001002, 32'h0,        32'h80FF1234, 4, 1, 4'b1100, 32'h0,        32'hFFFF80FF, 1};
    vecs[4]  = '{MEMOP_LHU,  32'h00001000, 32'h0,        32'h80FF1234, 6, 1, 4'b0011, 32'h0,        32'h00001234, 1};
    vecs[5]  = '{MEMOP_LB,   32'h00001001, 32'h0,        32'h80FF1234, 7, 1, 4'b0010, 32'h0,        32'h00000012, 1};
    vecs[6]  = '{MEMOP_LW,   32'h00001004, 32'h0,        32'hDEADBEEF, 8, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 1};
    vecs[7]  = '{MEMOP_SH,   32'h00002002, 32'h0000ABCD, 32'h0,        9, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0};
    vecs[8]  = '{MEMOP_SB,   32'h00002001, 32'h123456A5, 32'h0,        10, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,       0};
    vecs[9]  = '{MEMOP_SW,   32'h00002008, 32'hCAFEF00D, 32'h0,        11, 0, 4'b1111, 32'hCAFEF00D, 32'h0,       0};
    vecs[10] = '{MEMOP_NONE, 32'hFFFFFFFF, 32'h0,        32'h0,        31, 0, 4'b0000, 32'h0,        32'hFFFFFFFF, 0};
    vecs[11] = '{MEMOP_LH,   32'h00001000, 32'h0,        32'h0000F00F, 12, 1, 4'b0011, 32'h0,       32'hFFFFF00F, 1};

    // ---- Reset with random inputs ----
    rst = 1'b1;
    dmem_rdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      ex_valid      = 1'($urandom);
      flush         = 1'($urandom);
      dmem_ack      = 1'($urandom);
      ex_mem_op     = 4'($urandom_range(0, 8));
      ex_alu_result = $urandom;
      ex_store_data = $urandom;
      ex_rd         = 5'($urandom);
      ex_reg_write  = 1'($urandom);
      dmem_rdata    = $urandom;
      @(negedge clk);
    end
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbrd", 32'(wb_rd), 32'd0);
    chk("rst_wbrw", 32'(wb_reg_write), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_aexc", 32'(addr_exc), 32'd0);
    chk("rst_badva", bad_vaddr, 32'd0);
    rst = 1'b0;
    idle_in();
    @(negedge clk);

    // ---- Table-driven single transactions, ack one cycle after req ----
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rd, vecs[i].rw);
      @(negedge clk);
      ex_valid = 1'b0;
      if (vecs[i].op == MEMOP_NONE) begin
        chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d_wbdata", i), wb_data, vecs[i].wb_data);
        chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wbrw", i), 32'(wb_reg_write), 32'(vecs[i].wb_rw));
        chk($sformatf("v%0d_noreq", i), 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_wbv_pulse", i), 32'(wb_valid), 32'd0);
      end else begin
        chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'd1);
        chk($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].be));
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(is_store(vecs[i].op)));
        if (is_store(vecs[i].op))
          chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_wbv0", i), 32'(wb_valid), 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = vecs[i].rdata;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wbrw", i), 32'(wb_reg_write), 32'(vecs[i].wb_rw));
        if (is_load(vecs[i].op))
          chk($sformatf("v%0d_wbdata", i), wb_data, vecs[i].wb_data);
        chk($sformatf("v%0d_req_drop", i), 32'(dmem_req), 32'd0);
        chk($sformatf("v%0d_stall_drop", i), 32'(mem_stall), 32'd0);
      end
    end
    idle_in();
    @(negedge clk);

    // ---- Flush in IDLE: input discarded, no request ----
    drive(MEMOP_LW, 32'h00001000, 32'h0, 5'd1, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    idle_in();
    chk("fidle_req", 32'(dmem_req), 32'd0);
    chk("fidle_stall", 32'(mem_stall), 32'd0);
    chk("fidle_wbv", 32'(wb_valid), 32'd0);
    drive(MEMOP_NONE, 32'h00000077, 32'h0, 5'd1, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    idle_in();
    chk("fidle_none_wbv", 32'(wb_valid), 32'd0);

    // ---- LW, ack 3 cycles late, flush in 2nd ACCESS cycle ----
    drive(MEMOP_LW, 32'h00001008, 32'h0, 5'd13, 1'b1);
    stall_cnt = 0;
    wbv_cnt   = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      if (mem_stall) stall_cnt++;
      if (wb_valid)  wbv_cnt++;
      flush      = (k == 2);
      dmem_ack   = (k == 4);
      dmem_rdata = 32'h11111111;
    end
    idle_in();
    chk("flush_acc_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("flush_acc_wbv", 32'(wbv_cnt), 32'd0);
    chk("flush_acc_req", 32'(dmem_req), 32'd0);

    // Next LW retires normally (abort flag must have cleared)
    drive(MEMOP_LW, 32'h0000100C, 32'h0, 5'd14, 1'b1);
    @(negedge clk);
    ex_valid   = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("after_flush_wbv", 32'(wb_valid), 32'd1);
    chk("after_flush_wbdata", wb_data, 32'h0BADF00D);
    chk("after_flush_wbrd", 32'(wb_rd), 32'd14);

    // ---- Flush and ack in the same cycle ----
    drive(MEMOP_LW, 32'h00001010, 32'h0, 5'd15, 1'b1);
    @(negedge clk);
    ex_valid   = 1'b0;
    dmem_ack   = 1'b1;
    flush      = 1'b1;
    dmem_rdata = 32'h22222222;
    @(negedge clk);
    idle_in();
    chk("flush_ack_wbv", 32'(wb_valid), 32'd0);
    chk("flush_ack_stall", 32'(mem_stall), 32'd0);

    // ---- Timeout: never ack ----
    drive(MEMOP_LW, 32'h00001014, 32'h0, 5'd16, 1'b1);
    stall_cnt = 0;
    wbv_cnt   = 0;
    berr_cnt  = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      if (mem_stall) stall_cnt++;
      if (wb_valid)  wbv_cnt++;
      if (bus_err)   berr_cnt++;
      if (k == 4) chk("to_req_last", 32'(dmem_req), 32'd1);
      if (k == 5) begin
        chk("to_berr_at5", 32'(bus_err), 32'd1);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
      end
      // ack arriving in IDLE must be ignored
      dmem_ack = (k == 5);
    end
    idle_in();
    chk("to_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("to_berr_pulses", 32'(berr_cnt), 32'd1);
    chk("to_wbv", 32'(wbv_cnt), 32'd0);

    // ---- Reset in the middle of ACCESS ----
    drive(MEMOP_LW, 32'h00001018, 32'h0, 5'd17, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rstmid_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req", 32'(dmem_req), 32'd0);
    chk("rstmid_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);

    // ---- Misaligned LW @0x3002 ----
    drive(MEMOP_LW, 32'h00003002, 32'h0, 5'd18, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_aexc", 32'(addr_exc), 32'd1);
    chk("mis_badva", bad_vaddr, 32'h00003002);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    chk("mis_wbv", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("mis_aexc_pulse", 32'(addr_exc), 32'd0);
    chk("mis_badva_hold", bad_vaddr, 32'h00003002);
`else
    chk("mis_aexc", 32'(addr_exc), 32'd0);
    chk("mis_badva", bad_vaddr, 32'd0);
    chk("mis_req", 32'(dmem_req), 32'd1);
    chk("mis_addr", dmem_addr, 32'h00003000);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h33334444;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("mis_wbv", 32'(wb_valid), 32'd1);
    chk("mis_wbdata", wb_data, 32'h33334444);
`endif
    idle_in();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
